// File: rtl/display_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : display_sequencer
// Brief   : Steps a display through NUM_GROUPS x ENTRIES values taken from a
//           flat bus. Edge-detected step/back buttons, optional auto-scroll,
//           selectable wrap behaviour and a registered display output.
// Revision: 1.0 - initial release
// ============================================================================
module display_sequencer #(
   parameter int unsigned DATA_W     = 8,
   parameter int unsigned NUM_GROUPS = 3,
   parameter int unsigned ENTRIES    = 4,
   parameter int unsigned AUTO_DIV   = 50,
   parameter int unsigned WRAP_IDLE  = 1,
   localparam int unsigned GRP_W = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1,
   localparam int unsigned ENT_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1
) (
   input  logic                                   clk,
   input  logic                                   reset_n,
   input  logic [NUM_GROUPS*ENTRIES*DATA_W-1:0]   data_in,
   input  logic                                   step,
   input  logic                                   back,
   input  logic                                   auto_en,
   output logic [DATA_W-1:0]                      displayed,
   output logic                                   active,
   output logic [GRP_W-1:0]                       cur_group,
   output logic [ENT_W-1:0]                       cur_entry,
   output logic                                   wrap_pulse
);

   localparam int unsigned NUM_IDX = NUM_GROUPS * ENTRIES;
   localparam int unsigned IDX_W   = (NUM_IDX > 1) ? $clog2(NUM_IDX) : 1;
   localparam int unsigned CNT_W   = $clog2(AUTO_DIV);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_IDX - 1);
   localparam logic [GRP_W-1:0] LAST_GRP = GRP_W'(NUM_GROUPS - 1);
   localparam logic [ENT_W-1:0] LAST_ENT = ENT_W'(ENTRIES - 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(AUTO_DIV - 1);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_SHOW = 1'b1
   } state_t;

   state_t            state_q, state_d;
   logic [IDX_W-1:0]  idx_q,   idx_d;
   logic [GRP_W-1:0]  grp_q,   grp_d;
   logic [ENT_W-1:0]  ent_q,   ent_d;
   logic [CNT_W-1:0]  cnt_q,   cnt_d;
   logic [DATA_W-1:0] disp_q,  disp_d;
   logic              wrap_q,  wrap_d;
   logic              step_q,  step_d;
   logic              back_q,  back_d;

   logic              step_rise;
   logic              back_rise;
   logic              tick;
   logic              fwd;
   logic              bwd;

   // Button edge detection, auto-scroll tick and move events.
   always_comb begin
      step_d    = step;
      back_d    = back;
      step_rise = step & ~step_q;
      back_rise = back & ~back_q;
      tick      = auto_en & (cnt_q == CNT_LAST);
      fwd       = step_rise | tick;
      bwd       = back_rise;
   end

   // Auto-scroll period counter; any manual action restarts the period.
   always_comb begin
      cnt_d = cnt_q + 1'b1;
      if (!auto_en || step_rise || back_rise || (cnt_q == CNT_LAST)) begin
         cnt_d = '0;
      end
   end

   // Next-state logic; group/entry are tracked alongside idx so no divider is needed.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      grp_d   = grp_q;
      ent_d   = ent_q;
      wrap_d  = 1'b0;
      if (fwd && !bwd) begin
         if (state_q == ST_IDLE) begin
            state_d = ST_SHOW;
            idx_d   = '0;
            grp_d   = '0;
            ent_d   = '0;
         end else if (idx_q == LAST_IDX) begin
            wrap_d  = 1'b1;
            idx_d   = '0;
            grp_d   = '0;
            ent_d   = '0;
            if (WRAP_IDLE != 0) begin
               state_d = ST_IDLE;
            end
         end else begin
            idx_d = idx_q + 1'b1;
            if (ent_q == LAST_ENT) begin
               ent_d = '0;
               grp_d = grp_q + 1'b1;
            end else begin
               ent_d = ent_q + 1'b1;
            end
         end
      end else if (bwd && !fwd) begin
         if (state_q == ST_IDLE) begin
            state_d = ST_SHOW;
            idx_d   = LAST_IDX;
            grp_d   = LAST_GRP;
            ent_d   = LAST_ENT;
         end else if (idx_q == '0) begin
            if (WRAP_IDLE != 0) begin
               state_d = ST_IDLE;
               idx_d   = '0;
               grp_d   = '0;
               ent_d   = '0;
            end else begin
               idx_d   = LAST_IDX;
               grp_d   = LAST_GRP;
               ent_d   = LAST_ENT;
            end
         end else begin
            idx_d = idx_q - 1'b1;
            if (ent_q == '0) begin
               ent_d = LAST_ENT;
               grp_d = grp_q - 1'b1;
            end else begin
               ent_d = ent_q - 1'b1;
            end
         end
      end
   end

   // Display value follows the current index one cycle later, tracking live data.
   always_comb begin
      disp_d = '0;
      if (state_q == ST_SHOW) begin
         disp_d = data_in[idx_q*DATA_W +: DATA_W];
      end
   end

   // State registers; buttons reset as "held" so a press across reset release is ignored.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
         grp_q   <= '0;
         ent_q   <= '0;
         cnt_q   <= '0;
         disp_q  <= '0;
         wrap_q  <= 1'b0;
         step_q  <= 1'b1;
         back_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         grp_q   <= grp_d;
         ent_q   <= ent_d;
         cnt_q   <= cnt_d;
         disp_q  <= disp_d;
         wrap_q  <= wrap_d;
         step_q  <= step_d;
         back_q  <= back_d;
      end
   end

   assign displayed  = disp_q;
   assign active     = (state_q == ST_SHOW);
   assign cur_group  = grp_q;
   assign cur_entry  = ent_q;
   assign wrap_pulse = wrap_q;

endmodule
`default_nettype wire

// File: tb/tb_display_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_display_sequencer
// Brief   : Directed bench for display_sequencer. Two instances share inputs:
//           one returns to IDLE past the ends, the other wraps around.
// Revision: 1.0 - initial release
// ============================================================================
module tb_display_sequencer;

   localparam int DW = 8;
   localparam int NG = 3;
   localparam int NE = 4;
   localparam int AD = 4;
   localparam int N  = NG * NE;

   logic            clk     = 1'b0;
   logic            reset_n = 1'b0;
   logic            step    = 1'b1;
   logic            back    = 1'b0;
   logic            auto_en = 1'b0;
   logic [N*DW-1:0] data_in = '0;

   logic [DW-1:0] disp_a, disp_b;
   logic          act_a, act_b, wrap_a, wrap_b;
   logic [1:0]    grp_a, grp_b, ent_a, ent_b;

   display_sequencer #(.DATA_W(DW), .NUM_GROUPS(NG), .ENTRIES(NE), .AUTO_DIV(AD), .WRAP_IDLE(1)) dut_a (
      .clk(clk), .reset_n(reset_n), .data_in(data_in), .step(step), .back(back), .auto_en(auto_en),
      .displayed(disp_a), .active(act_a), .cur_group(grp_a), .cur_entry(ent_a), .wrap_pulse(wrap_a));

   display_sequencer #(.DATA_W(DW), .NUM_GROUPS(NG), .ENTRIES(NE), .AUTO_DIV(AD), .WRAP_IDLE(0)) dut_b (
      .clk(clk), .reset_n(reset_n), .data_in(data_in), .step(step), .back(back), .auto_en(auto_en),
      .displayed(disp_b), .active(act_b), .cur_group(grp_b), .cur_entry(ent_b), .wrap_pulse(wrap_b));

   always #5 clk = ~clk;

   int total  = 0;
   int bad    = 0;
   int wcnt_a = 0;
   int wcnt_b = 0;

   // Model: position -1 means IDLE, otherwise the linear entry index.
   // Index 0 of each array models the return-to-IDLE instance, index 1 the wrapping one.
   int pos[2]    = '{-1, -1};
   int m_disp[2] = '{0, 0};
   int m_wrap[2] = '{0, 0};
   int m_cnt     = 0;
   bit m_ps      = 1'b1;
   bit m_pb      = 1'b1;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int entry_val(input int k);
      logic [DW-1:0] v;
      v = data_in[k*DW +: DW];
      return int'(v);
   endfunction

   task automatic model_reset();
      for (int m = 0; m < 2; m++) begin
         pos[m]    = -1;
         m_disp[m] = 0;
         m_wrap[m] = 0;
      end
      m_cnt = 0;
      m_ps  = 1'b1;
      m_pb  = 1'b1;
   endtask

   // Predict the outputs after the next rising edge from the inputs now applied.
   task automatic model_advance();
      bit sr, br, tk, f, b;
      sr = step && !m_ps;
      br = back && !m_pb;
      tk = auto_en && (m_cnt == AD - 1);
      f  = sr || tk;
      b  = br;
      for (int m = 0; m < 2; m++) begin
         m_disp[m] = (pos[m] < 0) ? 0 : entry_val(pos[m]);
         m_wrap[m] = 0;
         if (f && !b) begin
            if (pos[m] < 0)           pos[m] = 0;
            else if (pos[m] == N - 1) begin
               m_wrap[m] = 1;
               pos[m]    = (m == 0) ? -1 : 0;
            end else                  pos[m] = pos[m] + 1;
         end else if (b && !f) begin
            if (pos[m] < 0)           pos[m] = N - 1;
            else if (pos[m] == 0)     pos[m] = (m == 0) ? -1 : N - 1;
            else                      pos[m] = pos[m] - 1;
         end
      end
      m_cnt = (!auto_en || sr || br) ? 0 : (m_cnt + 1) % AD;
      m_ps  = step;
      m_pb  = back;
   endtask

   task automatic cmp_dut(input int m, input int d, input int a, input int g, input int e, input int w);
      chk($sformatf("displayed[%0d]", m), d, m_disp[m]);
      chk($sformatf("active[%0d]", m),    a, (pos[m] >= 0) ? 1 : 0);
      chk($sformatf("cur_group[%0d]", m), g, (pos[m] < 0) ? 0 : pos[m] / NE);
      chk($sformatf("cur_entry[%0d]", m), e, (pos[m] < 0) ? 0 : pos[m] % NE);
      chk($sformatf("wrap_pulse[%0d]", m), w, m_wrap[m]);
   endtask

   // Per-cycle comparison against the model, sampled mid-cycle.
   initial begin
      forever begin
         @(negedge clk);
         if (!reset_n) model_reset();
         cmp_dut(0, int'(disp_a), int'(act_a), int'(grp_a), int'(ent_a), int'(wrap_a));
         cmp_dut(1, int'(disp_b), int'(act_b), int'(grp_b), int'(ent_b), int'(wrap_b));
         if (wrap_a) wcnt_a++;
         if (wrap_b) wcnt_b++;
         if (reset_n) model_advance();
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   task automatic press_step();
      step = 1'b1; cyc();
      step = 1'b0; cyc();
   endtask

   task automatic press_back();
      back = 1'b1; cyc();
      back = 1'b0; cyc();
   endtask

   initial begin
      for (int k = 0; k < N; k++) data_in[k*DW +: DW] = 8'(16 + k);

      // 1: step held across reset release is ignored until released
      repeat (2) cyc();
      reset_n = 1'b1;
      repeat (5) cyc();
      chk("t1_idle_active", int'(act_a), 0);
      chk("t1_idle_disp",   int'(disp_a), 0);
      step = 1'b0;
      cyc();
      press_step();
      chk("t1_first_disp",  int'(disp_a), 8'h10);
      chk("t1_first_act",   int'(act_a), 1);
      chk("t1_first_entry", int'(ent_a), 0);

      // 2: walk all entries, then off the end
      for (int i = 1; i < N; i++) begin
         press_step();
         chk($sformatf("t2_disp_%0d", i), int'(disp_a), 16 + i);
      end
      chk("t2_model_pos", pos[0], 11);
      press_step();
      chk("t2_end_act",   int'(act_a), 0);
      chk("t2_end_disp",  int'(disp_a), 0);
      chk("t2_wrap_cnt_a", wcnt_a, 1);
      chk("t2_wrap_cnt_b", wcnt_b, 1);
      chk("t2_b_disp",    int'(disp_b), 8'h10);
      chk("t2_b_act",     int'(act_b), 1);

      // 3: back from IDLE lands on the last entry; back from entry 0 wraps in dut_b
      press_back();
      chk("t3_disp",  int'(disp_a), 8'h1B);
      chk("t3_group", int'(grp_a), 2);
      chk("t3_entry", int'(ent_a), 3);
      chk("t3_b_disp", int'(disp_b), 8'h1B);
      chk("t3_wrap_cnt_b", wcnt_b, 1);

      // 4: simultaneous step/back at entry 5 does not move; live data follows
      repeat (6) press_back();
      chk("t4_group", int'(grp_a), 1);
      chk("t4_entry", int'(ent_a), 1);
      step = 1'b1; back = 1'b1; cyc();
      step = 1'b0; back = 1'b0; cyc();
      chk("t4_both_disp",  int'(disp_a), 8'h15);
      chk("t4_both_entry", int'(ent_a), 1);
      chk("t4_wrap_cnt_a", wcnt_a, 1);
      data_in[5*DW +: DW] = 8'hA5;
      cyc();
      chk("t4_live_disp", int'(disp_a), 8'hA5);

      // 5: auto-scroll every AD cycles; a manual press restarts the period
      auto_en = 1'b1;
      repeat (4) cyc();
      chk("t5_auto_group", int'(grp_a), 1);
      chk("t5_auto_entry", int'(ent_a), 2);
      repeat (2) cyc();
      step = 1'b1; cyc();
      step = 1'b0;
      chk("t5_press_entry", int'(ent_a), 3);
      repeat (3) cyc();
      chk("t5_hold_entry", int'(ent_a), 3);
      cyc();
      chk("t5_next_group", int'(grp_a), 2);
      chk("t5_next_entry", int'(ent_a), 0);
      auto_en = 1'b0;
      cyc();

      // 6: wrapping instance returns to entry 0; async reset mid-run
      repeat (3) press_step();
      chk("t6_last_entry_b", int'(ent_b), 3);
      press_step();
      chk("t6_b_entry", int'(ent_b), 0);
      chk("t6_b_group", int'(grp_b), 0);
      chk("t6_b_disp",  int'(disp_b), 8'h10);
      chk("t6_b_act",   int'(act_b), 1);
      chk("t6_a_act",   int'(act_a), 0);
      chk("t6_wrap_cnt_b", wcnt_b, 2);
      repeat (2) press_step();
      @(posedge clk);
      #3;
      reset_n = 1'b0;
      #1;
      chk("t6_rst_disp_a", int'(disp_a), 0);
      chk("t6_rst_act_a",  int'(act_a), 0);
      chk("t6_rst_disp_b", int'(disp_b), 0);
      chk("t6_rst_act_b",  int'(act_b), 0);
      chk("t6_rst_grp_b",  int'(grp_b), 0);
      chk("t6_rst_ent_b",  int'(ent_b), 0);
      repeat (2) cyc();
      reset_n = 1'b1;
      repeat (3) cyc();
      chk("t6_post_act_a", int'(act_a), 0);
      press_step();
      chk("t6_post_disp_a", int'(disp_a), 8'h10);
      cyc();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
